latch_bank_sequencer: RTL and testbench
=======================================

Name: latch_bank_sequencer

Overview:
- Sequences writes and clears into a bank of NLATCH octal D-latch registers (positive-edge-clocked, async active-low clear).
- Shares the bank between two requesters, A (main CPU) and B (sub CPU), with round-robin arbitration.
- Each transaction places data on the shared latch D bus, then produces a clean clock strobe or clear pulse for one latch, then acknowledges.
- Sits between the CPU address decoders and the latch bank feeding sound/video control lines.

Parameters:
NLATCH, 4, number of latches in the bank (2..8)
AW, 3, select-address width; must satisfy 2**AW >= NLATCH
STROBE_CYC, 2, cycles the latch clock or clear pulse is held active (1..15)

Ports:
Clk  in  1  system clock; all state changes on its rising edge
RESETn  in  1  asynchronous active-low reset
req_a  in  1  requester A transaction request (level)
clr_a  in  1  A: 1 = clear the latch, 0 = write it
addr_a  in  AW  A: latch select
data_a  in  8  A: write data
ack_a  out  1  A: one-cycle done pulse
req_b, clr_b, addr_b, data_b, ack_b  as above, for requester B
lat_d  out  8  shared latch D bus
lat_clk  out  NLATCH  per-latch clock strobe
lat_rst_n  out  NLATCH  per-latch active-low clear
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: async on RESETn low.
  - Values: state=IDLE; lat_d=0; lat_clk=0; ack_a=ack_b=0; busy=0; rr pointer favours A.
  - lat_rst_n is forced to all-0 combinationally while RESETn is low, so the system reset clears every latch.
  - Reset mid-transaction aborts it with no ack; a strobe in progress drops to 0 immediately.
- All other outputs are registered.
- FSM states and transitions:
  - IDLE: sample req_a/req_b.
    - One asserted: grant it.
    - Both asserted: grant the rr-favoured one; the pointer then favours the other requester.
    - Latch grant id, clr, addr and data into internal registers; next state SETUP.
  - SETUP, 1 cycle: lat_d = latched data (write) or unchanged (clear); all strobes inactive. Next: STROBE.
  - STROBE, STROBE_CYC cycles, counted by a 4-bit counter:
    - Write: lat_clk[addr]=1.
    - Clear: lat_rst_n[addr]=0.
    - Next: HOLD.
  - HOLD, 1 cycle: strobes inactive; lat_d still held. Next: ACK.
  - ACK, 1 cycle: ack of the granted requester =1. Next: IDLE.
- Timing:
  - lat_d is stable ≥1 cycle before and after each lat_clk rising and falling edge.
  - Latency from the IDLE sample to the ack cycle is 3+STROBE_CYC cycles; the default is 5.
- Handshake:
  - The requester holds req, clr, addr and data stable from assertion until it sees ack.
  - The requester deasserts req at the edge ending the ack cycle.
  - A req still high in the following IDLE is a new transaction.
  - Requester inputs are only sampled in IDLE; changes elsewhere are ignored.
- Starvation: after a grant to A with both requesting, B is served next, and vice versa. Maximum wait is one transaction.
- Out-of-range addr (>= NLATCH): no strobe or clear is generated; the full sequence and ack still occur.
- lat_d keeps its last written value between transactions.

Decomposition:
- Shared package latch_seq_pkg:
  - state enum (IDLE, SETUP, STROBE, HOLD, ACK)
  - requester id constants REQ_A=0, REQ_B=1
  - STROBE counter width constant 4
- One sub-module, latch_rr_arb2:
  - two-input round-robin grant with a 1-bit pointer
  - updates only on an IDLE grant
- FSM, capture registers and strobe decode stay in the top.

Test Plan:
- Reset: hold RESETn=0 → lat_rst_n=0000, lat_clk=0000, busy=0. Release → lat_rst_n=1111, IDLE.
- Single write: req_a=1, addr_a=2, data_a=8'hA5, clr_a=0.
  - lat_d=A5 one cycle before the strobe.
  - lat_clk=0100 for 2 cycles.
  - ack_a pulse exactly 5 cycles after sampling.
  - A latch model shows Q=A5.
- Contention: req_a and req_b both high in the same IDLE, data 8'h11 / 8'h22.
  - A is served first, then B.
  - Repeat → B is served first. The latch model ends at 22 after the first pair and 11 after the second pair.
- Clear: preload latch 1 with 8'hFF, then req_b with clr_b=1, addr_b=1.
  - lat_rst_n=1101 for STROBE_CYC cycles; lat_clk stays 0.
  - ack_b asserted; latch model shows 00.
- Boundary: addr_a=7 with NLATCH=4 → no lat_clk or lat_rst_n activity; ack_a still arrives after 5 cycles.
- Mid-operation reset: assert RESETn=0 during STROBE.
  - lat_clk drops to 0 immediately and lat_rst_n=0000.
  - No ack after release; the next request is served normally.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// Shared types and constants for the latch bank sequencer and its arbiter.
package latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK
  } seq_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/latch_rr_arb2.sv
// Two-input round-robin arbiter. The pointer flips only when both requesters
// compete in an IDLE cycle, so a lone requester never steals the other's turn.
module latch_rr_arb2
  import latch_seq_pkg::*;
(
  input  logic Clk,
  input  logic RESETn,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_valid,
  output logic gnt_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_valid = req_a | req_b;
    if (req_a && req_b) begin
      gnt_id = ptr_q;
    end else if (req_b) begin
      gnt_id = REQ_B;
    end else begin
      gnt_id = REQ_A;
    end
    ptr_d = ptr_q;
    if (en && req_a && req_b) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge Clk or negedge RESETn) begin
    if (!RESETn) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latch_bank_sequencer.sv
// Arbitrates two requesters onto a bank of octal latches, issuing a registered
// SETUP / STROBE / HOLD / ACK sequence for each write or clear.
module latch_bank_sequencer
  import latch_seq_pkg::*;
#(
  parameter int NLATCH     = 4,
  parameter int AW         = 3,
  parameter int STROBE_CYC = 2
) (
  input  logic              Clk,
  input  logic              RESETn,
  input  logic              req_a,
  input  logic              clr_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [7:0]        data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic              clr_b,
  input  logic [AW-1:0]     addr_b,
  input  logic [7:0]        data_b,
  output logic              ack_b,
  output logic [7:0]        lat_d,
  output logic [NLATCH-1:0] lat_clk,
  output logic [NLATCH-1:0] lat_rst_n,
  output logic              busy
);

  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              clr_q, clr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        lat_d_q, lat_d_d;
  logic [NLATCH-1:0] lat_clk_q, lat_clk_d;
  logic [NLATCH-1:0] lat_rst_n_q, lat_rst_n_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              busy_q, busy_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic [NLATCH-1:0] sel;

  latch_rr_arb2 u_arb (
    .Clk      (Clk),
    .RESETn   (RESETn),
    .req_a    (req_a),
    .req_b    (req_b),
    .en       (state_q == IDLE),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // Out-of-range addresses match no bit, so they run the full sequence silently.
  for (genvar gi = 0; gi < NLATCH; gi++) begin : g_sel
    assign sel[gi] = (addr_q == AW'(gi));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    clr_d       = clr_q;
    addr_d      = addr_q;
    lat_d_d     = lat_d_q;
    lat_clk_d   = '0;
    lat_rst_n_d = '1;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d   = gnt_id;
          clr_d   = (gnt_id == REQ_A) ? clr_a : clr_b;
          addr_d  = (gnt_id == REQ_A) ? addr_a : addr_b;
          // Data goes onto the bus now so it is settled throughout SETUP.
          if (!clr_d) begin
            lat_d_d = (gnt_id == REQ_A) ? data_a : data_b;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d       = '0;
        lat_clk_d   = clr_q ? '0 : sel;
        lat_rst_n_d = clr_q ? ~sel : '1;
        state_d     = STROBE;
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = HOLD;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          lat_clk_d   = clr_q ? '0 : sel;
          lat_rst_n_d = clr_q ? ~sel : '1;
        end
      end
      HOLD: begin
        ack_a_d = (gnt_q == REQ_A);
        ack_b_d = (gnt_q == REQ_B);
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= REQ_A;
      clr_q       <= 1'b0;
      addr_q      <= '0;
      lat_d_q     <= '0;
      lat_clk_q   <= '0;
      lat_rst_n_q <= '1;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      clr_q       <= clr_d;
      addr_q      <= addr_d;
      lat_d_q     <= lat_d_d;
      lat_clk_q   <= lat_clk_d;
      lat_rst_n_q <= lat_rst_n_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      busy_q      <= busy_d;
    end
  end

  // System reset reaches the latches directly, not just through the register.
  assign lat_rst_n = lat_rst_n_q & {NLATCH{RESETn}};
  assign lat_clk   = lat_clk_q;
  assign lat_d     = lat_d_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed bench for latch_bank_sequencer with a behavioural model of the
// external octal latches driven by the DUT's strobe and clear lines.
module tb_latch_bank_sequencer;

  localparam int NLATCH = 4;
  localparam int AW     = 3;
  localparam int MAXK   = 16;

  logic              Clk;
  logic              RESETn;
  logic              req_a, clr_a, req_b, clr_b;
  logic [AW-1:0]     addr_a, addr_b;
  logic [7:0]        data_a, data_b;
  logic              ack_a, ack_b, busy;
  logic [7:0]        lat_d;
  logic [NLATCH-1:0] lat_clk, lat_rst_n;

  int n_vec = 0;
  int n_err = 0;

  logic [NLATCH-1:0] tr_clk [MAXK];
  logic [NLATCH-1:0] tr_rst [MAXK];
  logic [7:0]        tr_d   [MAXK];
  logic              tr_acka [MAXK];
  logic              tr_ackb [MAXK];
  logic              tr_busy [MAXK];

  latch_bank_sequencer #(.NLATCH(NLATCH), .AW(AW), .STROBE_CYC(2)) dut (
    .Clk      (Clk),
    .RESETn   (RESETn),
    .req_a    (req_a),
    .clr_a    (clr_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .ack_a    (ack_a),
    .req_b    (req_b),
    .clr_b    (clr_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .ack_b    (ack_b),
    .lat_d    (lat_d),
    .lat_clk  (lat_clk),
    .lat_rst_n(lat_rst_n),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  for (genvar gi = 0; gi < NLATCH; gi++) begin : g_lat
    logic [7:0] q;
    always @(posedge lat_clk[gi] or negedge lat_rst_n[gi]) begin
      if (!lat_rst_n[gi]) q <= 8'h00;
      else                q <= lat_d;
    end
  end

  // Records outputs at the falling edge of cycles 1..n after the request;
  // a requester drops req at the rising edge that ends its ack cycle.
  task automatic capture(input int n);
    logic da, db;
    for (int k = 1; k <= n; k++) begin
      @(negedge Clk);
      tr_clk[k]  = lat_clk;
      tr_rst[k]  = lat_rst_n;
      tr_d[k]    = lat_d;
      tr_acka[k] = ack_a;
      tr_ackb[k] = ack_b;
      tr_busy[k] = busy;
      da = ack_a;
      db = ack_b;
      if (da || db) begin
        @(posedge Clk);
        if (da) req_a = 1'b0;
        if (db) req_b = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    req_a = 0; clr_a = 0; addr_a = '0; data_a = '0;
    req_b = 0; clr_b = 0; addr_b = '0; data_b = '0;
    repeat (2) @(negedge Clk);
    n_vec++; if (lat_rst_n !== 4'b0000) begin n_err++; $display("FAIL reset_rst_n: got %b expected 0000", lat_rst_n); end
    n_vec++; if (lat_clk !== 4'b0000) begin n_err++; $display("FAIL reset_clk: got %b expected 0000", lat_clk); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (lat_d !== 8'h00) begin n_err++; $display("FAIL reset_lat_d: got %h expected 00", lat_d); end
    n_vec++; if ({ack_a, ack_b} !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b expected 00", {ack_a, ack_b}); end
    RESETn = 1'b1;
    repeat (2) @(negedge Clk);
    n_vec++; if (lat_rst_n !== 4'b1111) begin n_err++; $display("FAIL release_rst_n: got %b expected 1111", lat_rst_n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b expected 0", busy); end
    $display("txn reset done");
  endtask

  task automatic test_single_write();
    req_a = 1; clr_a = 0; addr_a = 3'd2; data_a = 8'hA5;
    capture(6);
    n_vec++; if (tr_d[1] !== 8'hA5) begin n_err++; $display("FAIL wr_setup_d: got %h expected a5", tr_d[1]); end
    n_vec++; if (tr_clk[1] !== 4'b0000) begin n_err++; $display("FAIL wr_setup_clk: got %b expected 0000", tr_clk[1]); end
    n_vec++; if (tr_busy[1] !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b expected 1", tr_busy[1]); end
    for (int k = 2; k <= 3; k++) begin
      n_vec++; if (tr_clk[k] !== 4'b0100) begin n_err++; $display("FAIL wr_strobe c%0d: got %b expected 0100", k, tr_clk[k]); end
    end
    n_vec++; if (tr_clk[4] !== 4'b0000) begin n_err++; $display("FAIL wr_hold_clk: got %b expected 0000", tr_clk[4]); end
    n_vec++; if (tr_d[4] !== 8'hA5) begin n_err++; $display("FAIL wr_hold_d: got %h expected a5", tr_d[4]); end
    for (int k = 1; k <= 6; k++) begin
      n_vec++; if (tr_acka[k] !== (k == 5)) begin n_err++; $display("FAIL wr_ack_a c%0d: got %b expected %b", k, tr_acka[k], (k == 5)); end
    end
    n_vec++; if (tr_busy[6] !== 1'b0) begin n_err++; $display("FAIL wr_idle_busy: got %b expected 0", tr_busy[6]); end
    n_vec++; if (g_lat[2].q !== 8'hA5) begin n_err++; $display("FAIL wr_latch2: got %h expected a5", g_lat[2].q); end
    $display("txn write A addr=2 data=a5 latch2=%h", g_lat[2].q);
  endtask

  task automatic test_contention(input logic [7:0] first_exp, input logic [7:0] second_exp,
                                 input logic a_first, input logic [7:0] latch_exp);
    req_a = 1; clr_a = 0; addr_a = 3'd0; data_a = 8'h11;
    req_b = 1; clr_b = 0; addr_b = 3'd0; data_b = 8'h22;
    capture(12);
    n_vec++; if (tr_d[1] !== first_exp) begin n_err++; $display("FAIL cont_first_d: got %h expected %h", tr_d[1], first_exp); end
    n_vec++; if (tr_d[7] !== second_exp) begin n_err++; $display("FAIL cont_second_d: got %h expected %h", tr_d[7], second_exp); end
    n_vec++; if (tr_acka[5] !== a_first) begin n_err++; $display("FAIL cont_ack_a c5: got %b expected %b", tr_acka[5], a_first); end
    n_vec++; if (tr_ackb[5] !== !a_first) begin n_err++; $display("FAIL cont_ack_b c5: got %b expected %b", tr_ackb[5], !a_first); end
    n_vec++; if (tr_acka[11] !== !a_first) begin n_err++; $display("FAIL cont_ack_a c11: got %b expected %b", tr_acka[11], !a_first); end
    n_vec++; if (tr_ackb[11] !== a_first) begin n_err++; $display("FAIL cont_ack_b c11: got %b expected %b", tr_ackb[11], a_first); end
    n_vec++; if (tr_clk[8] !== 4'b0001) begin n_err++; $display("FAIL cont_second_strobe: got %b expected 0001", tr_clk[8]); end
    n_vec++; if (g_lat[0].q !== latch_exp) begin n_err++; $display("FAIL cont_latch0: got %h expected %h", g_lat[0].q, latch_exp); end
    $display("txn contention pair first=%h second=%h latch0=%h", first_exp, second_exp, g_lat[0].q);
  endtask

  task automatic test_clear();
    req_a = 1; clr_a = 0; addr_a = 3'd1; data_a = 8'hFF;
    capture(6);
    n_vec++; if (g_lat[1].q !== 8'hFF) begin n_err++; $display("FAIL clr_preload: got %h expected ff", g_lat[1].q); end
    req_b = 1; clr_b = 1; addr_b = 3'd1; data_b = 8'h77;
    capture(6);
    for (int k = 1; k <= 6; k++) begin
      n_vec++; if (tr_rst[k] !== ((k == 2 || k == 3) ? 4'b1101 : 4'b1111)) begin n_err++; $display("FAIL clr_rst_n c%0d: got %b", k, tr_rst[k]); end
      n_vec++; if (tr_clk[k] !== 4'b0000) begin n_err++; $display("FAIL clr_clk c%0d: got %b expected 0000", k, tr_clk[k]); end
    end
    n_vec++; if (tr_ackb[5] !== 1'b1) begin n_err++; $display("FAIL clr_ack_b: got %b expected 1", tr_ackb[5]); end
    n_vec++; if (tr_d[3] !== 8'hFF) begin n_err++; $display("FAIL clr_lat_d_kept: got %h expected ff", tr_d[3]); end
    n_vec++; if (g_lat[1].q !== 8'h00) begin n_err++; $display("FAIL clr_latch1: got %h expected 00", g_lat[1].q); end
    $display("txn clear B addr=1 latch1=%h", g_lat[1].q);
  endtask

  task automatic test_out_of_range();
    req_a = 1; clr_a = 0; addr_a = 3'd7; data_a = 8'h5C;
    capture(6);
    for (int k = 1; k <= 6; k++) begin
      n_vec++; if (tr_clk[k] !== 4'b0000) begin n_err++; $display("FAIL oor_clk c%0d: got %b expected 0000", k, tr_clk[k]); end
      n_vec++; if (tr_rst[k] !== 4'b1111) begin n_err++; $display("FAIL oor_rst_n c%0d: got %b expected 1111", k, tr_rst[k]); end
    end
    n_vec++; if (tr_acka[5] !== 1'b1) begin n_err++; $display("FAIL oor_ack_a: got %b expected 1", tr_acka[5]); end
    n_vec++; if (tr_acka[4] !== 1'b0) begin n_err++; $display("FAIL oor_ack_early: got %b expected 0", tr_acka[4]); end
    $display("txn write A addr=7 (out of range)");
  endtask

  task automatic test_mid_reset();
    req_a = 1; clr_a = 0; addr_a = 3'd3; data_a = 8'h3C;
    repeat (2) @(negedge Clk);
    n_vec++; if (lat_clk !== 4'b1000) begin n_err++; $display("FAIL mr_strobe: got %b expected 1000", lat_clk); end
    RESETn = 1'b0;
    #1;
    n_vec++; if (lat_clk !== 4'b0000) begin n_err++; $display("FAIL mr_clk_drop: got %b expected 0000", lat_clk); end
    n_vec++; if (lat_rst_n !== 4'b0000) begin n_err++; $display("FAIL mr_rst_n: got %b expected 0000", lat_rst_n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b expected 0", busy); end
    req_a = 1'b0;
    repeat (2) @(negedge Clk);
    RESETn = 1'b1;
    capture(6);
    for (int k = 1; k <= 6; k++) begin
      n_vec++; if (tr_acka[k] !== 1'b0) begin n_err++; $display("FAIL mr_no_ack c%0d: got %b expected 0", k, tr_acka[k]); end
    end
    n_vec++; if (g_lat[3].q !== 8'h00) begin n_err++; $display("FAIL mr_latch3_cleared: got %h expected 00", g_lat[3].q); end
    req_a = 1; clr_a = 0; addr_a = 3'd3; data_a = 8'h5A;
    capture(6);
    n_vec++; if (tr_acka[5] !== 1'b1) begin n_err++; $display("FAIL mr_next_ack: got %b expected 1", tr_acka[5]); end
    n_vec++; if (g_lat[3].q !== 8'h5A) begin n_err++; $display("FAIL mr_next_latch3: got %h expected 5a", g_lat[3].q); end
    $display("txn reset during strobe, then write A addr=3 latch3=%h", g_lat[3].q);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention(8'h11, 8'h22, 1'b1, 8'h22);
    repeat (2) @(negedge Clk);
    test_contention(8'h22, 8'h11, 1'b0, 8'h11);
    test_clear();
    test_out_of_range();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
